local_history_table: RTL and testbench

// - Parametrised per-branch local history table (BHT) for the IF/ID front end. Generalises the single-port BHT.
// - NUM_LK lookup lanes read history combinationally at fetch and enqueue their indices into an in-order pending FIFO.
// - ID resolves branches in program order. Each resolve pops the FIFO head and shifts its direction into that entry.
// - Adds flush recovery, backpressure, underflow detection and optional write-to-read forwarding.

---
 rtl/local_history_table_if.sv | 38 +++
 rtl/local_history_table.sv | 123 ++++++++++++
 tb/tb_local_history_table.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/local_history_table_if.sv
// ============================================================================
// Module      : local_history_table_if
// Description : Fetch/resolve bundle between the front end (master) and the
//               local history table (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface local_history_table_if #(
   parameter int IDX_W  = 8,
   parameter int HIST_W = 8,
   parameter int NUM_LK = 2,
   parameter int CNT_W  = 3
);
   logic                     stall;
   logic                     flush;
   logic [NUM_LK-1:0]        lk_valid;
   logic [NUM_LK*IDX_W-1:0]  lk_idx;
   logic [NUM_LK*HIST_W-1:0] lk_hist;
   logic                     lk_ready;
   logic                     res_valid;
   logic                     res_is_branch;
   logic                     res_taken;
   logic [CNT_W-1:0]         pend_count;
   logic                     underflow_err;

   modport master (
      output stall, flush, lk_valid, lk_idx, res_valid, res_is_branch, res_taken,
      input  lk_hist, lk_ready, pend_count, underflow_err
   );

   modport slave (
      input  stall, flush, lk_valid, lk_idx, res_valid, res_is_branch, res_taken,
      output lk_hist, lk_ready, pend_count, underflow_err
   );
endinterface

`default_nettype wire

// File: rtl/local_history_table.sv
// ============================================================================
// Module      : local_history_table
// Description : Multi-lane per-branch local history table with an in-order
//               pending-index FIFO. Optional macro BHT_RW_BYPASS_EN forwards a
//               same-cycle update to a colliding lookup.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module local_history_table #(
   parameter int ENTRIES    = 256,
   parameter int IDX_W      = 8,
   parameter int HIST_W     = 8,
   parameter int NUM_LK     = 2,
   parameter int PEND_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   local_history_table_if.slave  bus
);

   localparam int PTR_W = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
   localparam int CNT_W = $clog2(PEND_DEPTH) + 1;

   logic [HIST_W-1:0] table_q [ENTRIES];
   logic [HIST_W-1:0] table_d [ENTRIES];
   logic [IDX_W-1:0]  fifo_q  [PEND_DEPTH];
   logic [IDX_W-1:0]  fifo_d  [PEND_DEPTH];
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              underflow_q, underflow_d;

   logic              lk_ready;
   logic              push_en;
   logic              pop_en;
   logic              upd_en;
   logic [IDX_W-1:0]  head_idx;
   logic [HIST_W-1:0] upd_val;
   logic [CNT_W-1:0]  n_push;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(PEND_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      lk_ready = (CNT_W'(PEND_DEPTH) - count_q) >= CNT_W'(NUM_LK);
      push_en  = lk_ready && !bus.stall && !bus.flush;
      pop_en   = bus.res_valid && !bus.flush && (count_q != '0);
      head_idx = fifo_q[head_q];
      upd_en   = pop_en && bus.res_is_branch;
      upd_val  = {table_q[head_idx][HIST_W-2:0], bus.res_taken};

      // Lanes claim consecutive tail slots in lane order.
      fifo_d = fifo_q;
      tail_d = tail_q;
      n_push = '0;
      if (push_en) begin
         for (int i = 0; i < NUM_LK; i++) begin
            if (bus.lk_valid[i]) begin
               fifo_d[tail_d] = bus.lk_idx[i*IDX_W +: IDX_W];
               tail_d         = ptr_inc(tail_d);
               n_push         = n_push + CNT_W'(1);
            end
         end
      end

      head_d      = pop_en ? ptr_inc(head_q) : head_q;
      count_d     = count_q + n_push - (pop_en ? CNT_W'(1) : CNT_W'(0));
      underflow_d = underflow_q | (bus.res_valid && !bus.flush && (count_q == '0));

      if (bus.flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end

      table_d = table_q;
      if (upd_en) begin
         table_d[head_idx] = upd_val;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int e = 0; e < ENTRIES; e++) begin
            table_q[e] <= '0;
         end
         for (int p = 0; p < PEND_DEPTH; p++) begin
            fifo_q[p] <= '0;
         end
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         underflow_q <= 1'b0;
      end else begin
         table_q     <= table_d;
         fifo_q      <= fifo_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         underflow_q <= underflow_d;
      end
   end

   for (genvar g = 0; g < NUM_LK; g++) begin : g_lane
      logic [IDX_W-1:0] lane_idx;
      assign lane_idx = bus.lk_idx[g*IDX_W +: IDX_W];
`ifdef BHT_RW_BYPASS_EN
      assign bus.lk_hist[g*HIST_W +: HIST_W] =
         (upd_en && (lane_idx == head_idx)) ? upd_val : table_q[lane_idx];
`else
      assign bus.lk_hist[g*HIST_W +: HIST_W] = table_q[lane_idx];
`endif
   end

   assign bus.lk_ready      = lk_ready;
   assign bus.pend_count    = count_q;
   assign bus.underflow_err = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_local_history_table.sv
// ============================================================================
// Module      : tb_local_history_table
// Description : Directed self-checking bench for local_history_table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_local_history_table;

   logic clk = 1'b0;
   logic resetn;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   local_history_table_if #(.IDX_W(8), .HIST_W(8), .NUM_LK(2), .CNT_W(3)) bus ();

   local_history_table #(
      .ENTRIES(256), .IDX_W(8), .HIST_W(8), .NUM_LK(2), .PEND_DEPTH(4)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   wire [7:0] h0 = bus.lk_hist[7:0];
   wire [7:0] h1 = bus.lk_hist[15:8];

`ifdef BHT_RW_BYPASS_EN
   localparam logic [7:0] BYP_EXP = 8'h03;
`else
   localparam logic [7:0] BYP_EXP = 8'h01;
`endif

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      bus.stall = 0; bus.flush = 0; bus.lk_valid = 2'b00; bus.lk_idx = '0;
      bus.res_valid = 0; bus.res_is_branch = 0; bus.res_taken = 0;
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      idle();
      bus.lk_idx = {8'd9, 8'd5};
      #3;
      total++; if (h0 !== 8'h00 || h1 !== 8'h00) begin bad++; $display("FAIL reset_hist got=%h/%h exp=00/00", h0, h1); end
      total++; if (bus.pend_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.pend_count); end
      total++; if (bus.lk_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.lk_ready); end
      total++; if (bus.underflow_err !== 1'b0) begin bad++; $display("FAIL reset_uf got=%b exp=0", bus.underflow_err); end
      tick(); tick();
      resetn = 1'b1;
      tick();
      total++; if (h0 !== 8'h00 || bus.pend_count !== 3'd0) begin bad++; $display("FAIL post_reset got=%h cnt=%0d exp=00 cnt=0", h0, bus.pend_count); end
   endtask

   task automatic test_basic;
      bus.lk_valid = 2'b11; bus.lk_idx = {8'd7, 8'd3};
      tick();
      bus.lk_valid = 2'b00;
      total++; if (bus.pend_count !== 3'd2) begin bad++; $display("FAIL basic_push_cnt got=%0d exp=2", bus.pend_count); end
      bus.res_valid = 1; bus.res_is_branch = 1; bus.res_taken = 1;
      tick();
      total++; if (bus.pend_count !== 3'd1) begin bad++; $display("FAIL basic_pop1_cnt got=%0d exp=1", bus.pend_count); end
      bus.res_taken = 0;
      tick();
      bus.res_valid = 0;
      #1;
      total++; if (bus.pend_count !== 3'd0) begin bad++; $display("FAIL basic_pop2_cnt got=%0d exp=0", bus.pend_count); end
      total++; if (h0 !== 8'h01) begin bad++; $display("FAIL basic_t3 got=%h exp=01", h0); end
      total++; if (h1 !== 8'h00) begin bad++; $display("FAIL basic_t7 got=%h exp=00", h1); end
   endtask

   task automatic push_resolve(input logic br, input logic tk);
      bus.lk_valid = 2'b01; bus.lk_idx = {8'd0, 8'd3};
      tick();
      bus.lk_valid = 2'b00;
      bus.res_valid = 1; bus.res_is_branch = br; bus.res_taken = tk;
      tick();
      bus.res_valid = 0;
   endtask

   task automatic test_shift;
      for (int k = 0; k < 8; k++) push_resolve(1'b1, 1'b1);
      #1;
      total++; if (h0 !== 8'hFF) begin bad++; $display("FAIL shift_ff got=%h exp=ff", h0); end
      push_resolve(1'b1, 1'b0);
      #1;
      total++; if (h0 !== 8'hFE) begin bad++; $display("FAIL shift_fe got=%h exp=fe", h0); end
      push_resolve(1'b0, 1'b1);
      #1;
      total++; if (h0 !== 8'hFE) begin bad++; $display("FAIL nonbranch_pop got=%h exp=fe", h0); end
      total++; if (bus.pend_count !== 3'd0) begin bad++; $display("FAIL shift_cnt got=%0d exp=0", bus.pend_count); end
   endtask

   task automatic test_full;
      bus.lk_valid = 2'b11; bus.lk_idx = {8'd2, 8'd1};
      tick(); tick();
      total++; if (bus.pend_count !== 3'd4) begin bad++; $display("FAIL full_cnt got=%0d exp=4", bus.pend_count); end
      total++; if (bus.lk_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", bus.lk_ready); end
      tick();
      bus.lk_valid = 2'b00;
      total++; if (bus.pend_count !== 3'd4) begin bad++; $display("FAIL full_ignored got=%0d exp=4", bus.pend_count); end
      bus.res_valid = 1; bus.res_is_branch = 0;
      tick();
      total++; if (bus.pend_count !== 3'd3 || bus.lk_ready !== 1'b0) begin bad++; $display("FAIL pop_to3 got=%0d/%b exp=3/0", bus.pend_count, bus.lk_ready); end
      tick();
      bus.res_valid = 0;
      total++; if (bus.pend_count !== 3'd2 || bus.lk_ready !== 1'b1) begin bad++; $display("FAIL pop_to2 got=%0d/%b exp=2/1", bus.pend_count, bus.lk_ready); end
      bus.stall = 1; bus.lk_valid = 2'b11;
      tick();
      bus.stall = 0;
      total++; if (bus.pend_count !== 3'd2) begin bad++; $display("FAIL stall_cnt got=%0d exp=2", bus.pend_count); end
      bus.lk_valid = 2'b01;
      tick();
      bus.lk_valid = 2'b00;
      total++; if (bus.pend_count !== 3'd3) begin bad++; $display("FAIL single_push got=%0d exp=3", bus.pend_count); end
   endtask

   task automatic test_flush;
      bus.flush = 1; bus.res_valid = 1; bus.res_is_branch = 1; bus.res_taken = 1; bus.lk_valid = 2'b11;
      tick();
      idle();
      bus.lk_idx = {8'd2, 8'd1};
      #1;
      total++; if (bus.pend_count !== 3'd0) begin bad++; $display("FAIL flush_cnt got=%0d exp=0", bus.pend_count); end
      total++; if (bus.underflow_err !== 1'b0) begin bad++; $display("FAIL flush_uf got=%b exp=0", bus.underflow_err); end
      total++; if (h0 !== 8'h00 || h1 !== 8'h00) begin bad++; $display("FAIL flush_table got=%h/%h exp=00/00", h0, h1); end
      bus.res_valid = 1; bus.res_is_branch = 1; bus.res_taken = 1;
      tick();
      bus.res_valid = 0;
      total++; if (bus.underflow_err !== 1'b1) begin bad++; $display("FAIL underflow_set got=%b exp=1", bus.underflow_err); end
      total++; if (bus.pend_count !== 3'd0 || h0 !== 8'h00) begin bad++; $display("FAIL underflow_nochange got=%0d/%h exp=0/00", bus.pend_count, h0); end
      tick();
      total++; if (bus.underflow_err !== 1'b1) begin bad++; $display("FAIL underflow_sticky got=%b exp=1", bus.underflow_err); end
   endtask

   task automatic test_midop_reset;
      bus.lk_valid = 2'b11; bus.lk_idx = {8'd3, 8'd3};
      #1;
      total++; if (h0 !== 8'hFE || h1 !== 8'hFE) begin bad++; $display("FAIL same_idx_read got=%h/%h exp=fe/fe", h0, h1); end
      tick();
      bus.lk_valid = 2'b00;
      total++; if (bus.pend_count !== 3'd2) begin bad++; $display("FAIL same_idx_push got=%0d exp=2", bus.pend_count); end
      resetn = 1'b0;
      #1;
      total++; if (bus.pend_count !== 3'd0 || bus.underflow_err !== 1'b0 || h0 !== 8'h00) begin
         bad++; $display("FAIL midop_reset got=cnt%0d uf%b h%h exp=cnt0 uf0 h00", bus.pend_count, bus.underflow_err, h0);
      end
      tick();
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_bypass;
      bus.lk_valid = 2'b11; bus.lk_idx = {8'd3, 8'd3};
      tick();
      bus.lk_valid = 2'b00;
      bus.res_valid = 1; bus.res_is_branch = 1; bus.res_taken = 1;
      tick();
      total++; if (bus.pend_count !== 3'd1 || h0 !== 8'h01) begin bad++; $display("FAIL bypass_setup got=%0d/%h exp=1/01", bus.pend_count, h0); end
      bus.lk_valid = 2'b01;
      #1;
      total++; if (h0 !== BYP_EXP || h1 !== BYP_EXP) begin bad++; $display("FAIL bypass_collide got=%h/%h exp=%h", h0, h1, BYP_EXP); end
      tick();
      bus.res_valid = 0; bus.lk_valid = 2'b00;
      #1;
      total++; if (h0 !== 8'h03) begin bad++; $display("FAIL bypass_next got=%h exp=03", h0); end
      total++; if (bus.pend_count !== 3'd1) begin bad++; $display("FAIL push_pop_cnt got=%0d exp=1", bus.pend_count); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_shift();
      test_full();
      test_flush();
      test_midop_reset();
      test_bypass();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
